// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch -- single-outstanding instruction fetch unit with PC sequencing.
//
// Issues one read per instruction, latches the returned word into IR, presents
// the decoded fields to the decode stage and holds them until accepted. On
// accept the PC advances to pc+4, a taken branch target or a jump target.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   imem_req / imem_addr  read request, address always equals pc
//   imem_rdata / imem_ack returned word and one-cycle completion strobe
//   instr_valid / instr_ready  handshake with the decode stage
//   Zero, branch, jump    control inputs, used only in the accept cycle
//   opcode..jtarget       field slices of IR
//   pc                    address of the instruction held in IR
//   fetch_err             sticky watchdog error
//
// Optional feature: define FETCH_WATCHDOG_EN to enable the S_WAIT watchdog,
// which flags fetch_err and reissues the fetch after TIMEOUT_CYCLES cycles.
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        Zero,
    input  logic        branch,
    input  logic        jump,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  func,
    output logic [15:0] imm16,
    output logic [25:0] jtarget,
    output logic [31:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_ir, r_pc;
    logic [31:0] w_pc4, w_br_off, w_pc_next;
    logic        w_load, w_accept, w_timeout;

    // Acks are only meaningful while a fetch is outstanding.
    assign w_load   = (r_state != S_VALID) && imem_ack;
    assign w_accept = (r_state == S_VALID) && instr_ready;

    assign w_pc4    = r_pc + 32'd4;
    assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    // Jump wins over branch when both are asserted.
    always_comb begin
        w_pc_next = w_pc4;
        if (jump)
            w_pc_next = {w_pc4[31:28], r_ir[25:0], 2'b00};
        else if (branch && Zero)
            w_pc_next = w_pc4 + w_br_off;
    end

`ifdef FETCH_WATCHDOG_EN
    logic [7:0] r_wdog;
    logic       r_err;

    // Fires on the last of TIMEOUT_CYCLES consecutive ack-less S_WAIT cycles.
    assign w_timeout = (r_state == S_WAIT) && !imem_ack
                       && (r_wdog == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= 8'd0;
            r_err  <= 1'b0;
        end else if (w_timeout) begin
            r_wdog <= 8'd0;
            r_err  <= 1'b1;
        end else if (r_state == S_WAIT && !imem_ack) begin
            r_wdog <= r_wdog + 8'd1;
        end else begin
            r_wdog <= 8'd0;
        end
    end

    assign fetch_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_REQ;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   w_next = imem_ack ? S_VALID : S_WAIT;
            S_WAIT: begin
                if (imem_ack)       w_next = S_VALID;
                else if (w_timeout) w_next = S_REQ;
            end
            S_VALID: if (instr_ready) w_next = S_REQ;
            default: w_next = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = (r_state != S_VALID);
        instr_valid = (r_state == S_VALID);
    end

    // IR and PC; the low PC bits are forced to zero so pc stays word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
            r_ir <= 32'd0;
        end else begin
            if (w_load)   r_ir <= imem_rdata;
            if (w_accept) r_pc <= w_pc_next;
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign opcode    = r_ir[31:26];
    assign rs        = r_ir[25:21];
    assign rt        = r_ir[20:16];
    assign rd        = r_ir[15:11];
    assign func      = r_ir[5:0];
    assign imm16     = r_ir[15:0];
    assign jtarget   = r_ir[25:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, 16, wait-cycle limit for the fetch watchdog (range 2..255).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  byte address of the fetch, equal to pc.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 imem_ack  input  1  read-complete strobe, one cycle.
REQ-009 instr_valid  output  1  decoded fields valid for the decode/control stage.
REQ-010 instr_ready  input  1  decode stage accepts the current instruction.
REQ-011 Zero  input  1  ALU equality result for the presented instruction.
REQ-012 branch, jump  input  1 each  control outputs for the presented instruction.
REQ-013 opcode[5:0]=IR[31:26], rs[4:0]=IR[25:21], rt[4:0]=IR[20:16], rd[4:0]=IR[15:11], func[5:0]=IR[5:0], imm16[15:0]=IR[15:0], jtarget[25:0]=IR[25:0]  output  field slices of the instruction register.
REQ-014 pc  output  32  address of the instruction held in IR.
REQ-015 fetch_err  output  1  sticky watchdog error flag.

Function
REQ-016 FSM states: S_REQ, S_WAIT, S_VALID.
- S_REQ: imem_req=1. ack goes to S_VALID; no ack goes to S_WAIT.
- S_WAIT: imem_req=1. ack goes to S_VALID.
- S_VALID: instr_valid=1. instr_ready goes to S_REQ; otherwise the block holds S_VALID.
REQ-017 On imem_ack in S_REQ or S_WAIT, the block SHALL load imem_rdata into IR; instr_valid SHALL rise the next cycle. Minimum latency: request to valid is 1 cycle; valid is asserted at most once per 2 cycles.
REQ-018 In S_VALID, IR and pc SHALL hold stable until instr_ready=1.
REQ-019 When instr_valid and instr_ready are both 1, pc SHALL update as follows:
- jump=1: {pc4[31:28], jtarget, 2'b00}.
- else branch and Zero both 1: pc4 + ({{14{imm16[15]}}, imm16, 2'b00}).
- else: pc4.
- pc4 = pc + 4. All sums are 32-bit modulo 2^32 with no carry out.
REQ-020 Jump SHALL take priority over branch when both are asserted.
REQ-021 branch, jump and Zero SHALL be ignored outside the accept cycle.
REQ-022 imem_ack outside S_REQ and S_WAIT SHALL be ignored; IR SHALL NOT change.
REQ-023 imem_addr SHALL equal pc in every cycle. pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 on sequential increment.
REQ-024 The two low bits of pc SHALL always be 2'b00.

Reset
REQ-025 rst=1 at a clock edge SHALL set state=S_REQ, pc=RESET_PC, IR=0, instr_valid=0, fetch_err=0 and watchdog count=0.
- imem_req SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset mid-operation (S_WAIT or S_VALID) SHALL abandon the outstanding fetch. A late imem_ack arriving in the first cycle after reset SHALL be accepted as the RESET_PC fetch.
REQ-027 rst SHALL take priority over all other inputs.

Configuration
REQ-028 Macro FETCH_WATCHDOG_EN, when defined:
- An 8-bit counter SHALL count cycles spent in S_WAIT.
- When the count reaches TIMEOUT_CYCLES, the block SHALL set fetch_err=1 (sticky until rst), clear the counter and return to S_REQ to reissue the same address.
- The counter SHALL clear on any ack.
REQ-029 Without FETCH_WATCHDOG_EN: no counter, fetch_err tied to 0, and S_WAIT waits indefinitely.

Verification
REQ-030 Reset, then ack in the same cycle as the request with rdata=32'h8C22_0004, ready held 1 -> opcode=6'b100011, rs=1, rt=2, imm16=4, pc=0; the next fetch is at 4.
REQ-031 Present IR at pc=32'h100 with ready=0 for 5 cycles -> instr_valid, IR and pc stable throughout; no imem_req.
REQ-032 BEQ at pc=32'h40 with imm16=16'hFFFE, branch=1, Zero=1 on accept -> next pc=32'h3C; the same case with Zero=0 -> next pc=32'h44.
REQ-033 jump=1 and branch=1, Zero=1 at pc=32'h9000_0010 with jtarget=26'h000_0040 -> next pc=32'h9000_0100.
REQ-034 FETCH_WATCHDOG_EN defined, TIMEOUT_CYCLES=16, ack withheld -> fetch_err=1 after 16 wait cycles; imem_req stays high at the same address; a later ack completes normally with fetch_err still 1.
REQ-035 rst pulsed in S_VALID at pc=32'h20 -> next cycle: pc=0, instr_valid=0, imem_req=1.
